// File: rtl/aes_inv_round_ctrl.sv
// rtl/aes_inv_round_ctrl.sv - iterative AES-128 inverse-cipher round controller
module aes_inv_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    output logic [3:0]   key_idx,
    input  logic [0:127] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_KEY = 4'(NR);
    localparam logic [3:0] FIRST_RND = 4'(NR - 1);

    state_t       state, state_d;
    logic [3:0]   rnd, rnd_d;
    logic [0:127] st, st_d;
    logic [0:127] round_out;

    // GF(2^8) multiply by x modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8) as x^254 (0 maps to 0)
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] a;
        logic [7:0] p;
        logic [7:0] r;
        a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [0:31] inv_mix_col(input logic [0:31] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[0:7];
        a1 = c[8:15];
        a2 = c[16:23];
        a3 = c[24:31];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // One inverse round; the final round bypasses InvMixColumns
    function automatic logic [0:127] inv_round(input logic [0:127] s,
                                               input logic [0:127] k,
                                               input logic         last);
        logic [0:127] t;
        logic [0:127] m;
        int           src;
        t = '0;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            // byte i = row (i%4), column (i/4); row r rotates right by r columns
            src = (i % 4) + 4 * (((i / 4) - (i % 4)) & 3);
            t[8*i +: 8] = inv_sbox(s[8*src +: 8]) ^ k[8*i +: 8];
        end
        for (int c = 0; c < 4; c++) begin
            m[32*c +: 32] = inv_mix_col(t[32*c +: 32]);
        end
        return last ? t : m;
    endfunction

    assign round_out = inv_round(st, round_key, (rnd == 4'd0));

    // State, round counter and block register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            rnd   <= 4'd0;
            st    <= '0;
        end else begin
            state <= state_d;
            rnd   <= rnd_d;
            st    <= st_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state;
        rnd_d   = rnd;
        st_d    = st;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    st_d    = in_data ^ round_key;
                    rnd_d   = FIRST_RND;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                st_d = round_out;
                if (rnd == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    rnd_d = rnd - 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        key_idx   = 4'd0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                key_idx  = LAST_KEY;
            end
            S_ROUND: begin
                busy    = 1'b1;
                key_idx = rnd;
            end
            S_DONE: begin
                out_valid = 1'b1;
                key_idx   = 4'd0;
            end
            default: key_idx = LAST_KEY;
        endcase
    end

    assign out_data = st;

endmodule

// File: doc/aes_inv_round_ctrl.md
# aes_inv_round_ctrl

Iterative AES-128 decryption engine controller: accepts a 128-bit ciphertext block, sequences the inverse-cipher datapath (inv_shiftrow, inverse S-box bank, AddRoundKey, inv_mixcolumns) through the initial key addition plus 10 rounds, one round per clock, and presents the plaintext block. It sits between the block-level input/output handshakes and the round-key store. It drives the round-key index and consumes the returned key in the same cycle.

## Interface
Parameters:
- NR, 10, number of rounds (AES-128 only; other values unsupported).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  ciphertext block valid.
- in_ready  output  1  controller can accept a block.
- in_data  input  [0:127]  ciphertext; bit 0 is MSB of state byte 0, bytes in column-major order.
- key_idx  output  4  round-key index requested this cycle, range 0..10.
- round_key  input  [0:127]  round key for key_idx; combinational, valid in the same cycle.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  downstream accepts plaintext.
- out_data  output  [0:127]  plaintext, same bit/byte ordering as in_data.
- busy  output  1  high in ROUND.

## Operation
- State register st[0:127], round counter rnd (4 bits), FSM states IDLE, ROUND, DONE.
- IDLE: in_ready=1, key_idx=10. When in_valid: st <= in_data ^ round_key; rnd <= 9; go to ROUND.
- ROUND: in_ready=0, busy=1, key_idx=rnd.
  - rnd 9..1: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ round_key); rnd <= rnd-1.
  - rnd 0: st <= InvSubBytes(InvShiftRows(st)) ^ round_key; no InvMixColumns; go to DONE.
- DONE: out_valid=1, out_data=st, key_idx=0. Hold st and out_valid stable until out_ready. When out_ready: go to IDLE.
- No back-to-back accept in DONE: in_ready stays 0 until the FSM has returned to IDLE, which takes 1 cycle after handoff.
- in_data, in_valid and round_key are ignored outside the cycles given above. Changes to in_data while in ROUND do not affect the block in flight.
- out_data equals st in all states. It is meaningful only while out_valid=1.
- Datapath: instantiate the team's existing inverse-round modules. The controller owns only st, rnd, FSM, key_idx and the final-round mux that bypasses InvMixColumns.

## Timing
- Reset (rst=1 at a clock edge), effective that edge: FSM=IDLE, rnd=0, st=0.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, key_idx=10, out_data=0.
- Reset mid-ROUND or in DONE: the block is discarded with no output, and the FSM is in IDLE the next cycle.
- Latency: accept at edge T0. ROUND occupies cycles T0+1..T0+10. out_valid rises after edge T0+10 and is visible in cycle T0+11 when out_ready is held high.
- Throughput: one block per 12 cycles when out_ready is held high (accept, 10 rounds, DONE, IDLE).
- key_idx is a registered-state decode (function of FSM/rnd only), never of the inputs. The key store must return round_key combinationally within the cycle.
- Key sequence per block: 10, 9, 8, …, 1, 0.
- Backpressure: out_ready low in DONE stalls indefinitely, with no change to out_data, out_valid or key_idx.
- in_valid in the same cycle as rst: ignored.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f (bench key store returns the expanded schedule), in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid exactly 11 cycles after accept, key_idx sequence 10,9,…,0.
- All-zero key and schedule, in_data = AES-128 encrypt of 0 under key 0 (66e94bd4ef8a2c3b884cfa59ca342b2e) -> out_data 0.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid/out_data stable, in_ready=0. Release -> one handoff, then IDLE with in_ready=1.
- Back-to-back: two C.1 blocks with in_valid held high and out_ready=1 -> two correct outputs, accepts 12 cycles apart.
- Reset at the 5th ROUND cycle, then a fresh C.1 block -> no out_valid for the aborted block, correct result for the fresh block, all outputs at reset values the cycle after rst.
- in_data toggled randomly during ROUND -> result unaffected.
